// File: rtl/ir_key_ctrl_pkg.sv
// Shared definitions for the NEC IR key controller: FSM state encoding,
// NEC frame field positions, remote key codes and key decode helpers.
package ir_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   // NEC frame byte positions (LSB of each byte)
   localparam int NEC_CUST_LSB  = 24;
   localparam int NEC_NCUST_LSB = 16;
   localparam int NEC_CMD_LSB   = 8;
   localparam int NEC_NCMD_LSB  = 0;

   // Remote key codes
   localparam logic [7:0] KEY_0     = 8'h16;
   localparam logic [7:0] KEY_1     = 8'h0C;
   localparam logic [7:0] KEY_2     = 8'h18;
   localparam logic [7:0] KEY_3     = 8'h5E;
   localparam logic [7:0] KEY_4     = 8'h08;
   localparam logic [7:0] KEY_5     = 8'h1C;
   localparam logic [7:0] KEY_6     = 8'h5A;
   localparam logic [7:0] KEY_7     = 8'h42;
   localparam logic [7:0] KEY_8     = 8'h52;
   localparam logic [7:0] KEY_9     = 8'h4A;
   localparam logic [7:0] KEY_LEFT  = 8'h44;
   localparam logic [7:0] KEY_RIGHT = 8'h40;
   localparam logic [7:0] KEY_UP    = 8'h15;
   localparam logic [7:0] KEY_DOWN  = 8'h07;
   localparam logic [7:0] KEY_CLEAR = 8'h45;

   // Returns {is_digit, value}; non-digit keys return 0.
   function automatic logic [4:0] key_digit(input logic [7:0] cmd);
      logic [4:0] r;
      case (cmd)
         KEY_0:   r = 5'h10;
         KEY_1:   r = 5'h11;
         KEY_2:   r = 5'h12;
         KEY_3:   r = 5'h13;
         KEY_4:   r = 5'h14;
         KEY_5:   r = 5'h15;
         KEY_6:   r = 5'h16;
         KEY_7:   r = 5'h17;
         KEY_8:   r = 5'h18;
         KEY_9:   r = 5'h19;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   // Only the navigation/adjust keys auto-repeat while held.
   function automatic logic key_repeatable(input logic [7:0] cmd);
      return (cmd == KEY_UP) || (cmd == KEY_DOWN) ||
             (cmd == KEY_LEFT) || (cmd == KEY_RIGHT);
   endfunction

endpackage

// File: rtl/ir_key_ctrl_if.sv
// Bundle of IR receiver inputs and display-side outputs of ir_key_ctrl.
// master drives frames/repeats, slave is the controller.
interface ir_key_ctrl_if;
   logic        i_frame_vld;
   logic [31:0] i_frame;
   logic        i_repeat_vld;
   logic [23:0] o_digits;
   logic [5:0]  o_cursor;
   logic [5:0]  o_dp;
   logic [7:0]  o_key;
   logic        o_key_vld;
   logic [7:0]  o_err_cnt;

   modport master (
      output i_frame_vld, i_frame, i_repeat_vld,
      input  o_digits, o_cursor, o_dp, o_key, o_key_vld, o_err_cnt
   );

   modport slave (
      input  i_frame_vld, i_frame, i_repeat_vld,
      output o_digits, o_cursor, o_dp, o_key, o_key_vld, o_err_cnt
   );
endinterface

// File: rtl/ir_key_ctrl_ms_tick.sv
// 1 ms tick generator: divides clk by CLK_HZ/1000 and emits a one-cycle
// pulse. Synchronous active-high reset restarts the period.
module ms_tick #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick
);

   localparam int DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 2;
   localparam int W   = $clog2(DIV);

   logic [W-1:0] cnt_q, cnt_d;
   logic         tick_q, tick_d;

   // down-counter reloads at terminal count and flags the tick
   always_comb begin
      cnt_d  = cnt_q - 1'b1;
      tick_d = 1'b0;
      if (cnt_q == '0) begin
         cnt_d  = W'(DIV - 1);
         tick_d = 1'b1;
      end
   end

   // register counter and tick
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= W'(DIV - 1);
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign o_tick = tick_q;

endmodule

// File: rtl/ir_key_ctrl.sv
// NEC IR command controller: validates frames, edits a six-digit BCD value
// with a blinking cursor and, when IR_REPEAT_EN is defined, auto-repeats
// held navigation keys from NEC repeat codes.
//
// state | meaning
// IDLE  | waiting for a frame
// CHECK | validating latched frame
// EXEC  | applying key, pulsing o_key_vld
// HOLD  | repeatable key held, watching repeat codes (IR_REPEAT_EN only)
module ir_key_ctrl
   import ir_ctrl_pkg::*;
#(
   parameter int         CLK_HZ          = 50_000_000,
   parameter logic [7:0] CUSTOM_CODE     = 8'h00,
   parameter int         REPEAT_DELAY_MS = 500,
   parameter int         HOLD_TIMEOUT_MS = 120,
   parameter int         BLINK_MS        = 250
) (
   input logic          clk,
   input logic          rst,
   ir_key_ctrl_if.slave bus
);

   localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

   state_t      state_q, state_d;
   logic [31:0] frame_q, frame_d;
   logic [23:0] digits_q, digits_d;
   logic [2:0]  cur_q, cur_d;
   logic [7:0]  key_q, key_d;
   logic        key_vld_q, key_vld_d;
   logic [7:0]  err_q, err_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic        blink_q, blink_d;
   logic        tick;

`ifdef IR_REPEAT_EN
   logic [15:0] press_q, press_d;
   logic [15:0] gap_q, gap_d;
   logic        rep_q, rep_d;
`else
   logic        unused_cfg;
   assign unused_cfg = bus.i_repeat_vld | (REPEAT_DELAY_MS == HOLD_TIMEOUT_MS);
`endif

   logic [7:0] f_custom, f_ncustom, f_cmd, f_ncmd;
   logic       frame_ok;
   logic [4:0] kd;
   logic [3:0] cur_dig;
   logic [2:0] cur_right, cur_left;

   ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
      .clk    (clk),
      .rst    (rst),
      .o_tick (tick)
   );

   assign f_custom  = frame_q[NEC_CUST_LSB  +: 8];
   assign f_ncustom = frame_q[NEC_NCUST_LSB +: 8];
   assign f_cmd     = frame_q[NEC_CMD_LSB   +: 8];
   assign f_ncmd    = frame_q[NEC_NCMD_LSB  +: 8];
   assign frame_ok  = (f_custom == CUSTOM_CODE) && (f_ncustom == ~f_custom) &&
                      (f_ncmd == ~f_cmd);
   assign kd        = key_digit(f_cmd);
   assign cur_dig   = digits_q[{cur_q, 2'b00} +: 4];
   // cursor index 5 is the leftmost digit, so "right" decrements
   assign cur_right = (cur_q == 3'd0) ? 3'd5 : cur_q - 3'd1;
   assign cur_left  = (cur_q >= 3'd5) ? 3'd0 : cur_q + 3'd1;

   // free-running blink phase, toggled every BLINK_MS ticks
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      if (tick) begin
         if (blink_cnt_q == '0) begin
            blink_cnt_d = BW'(BLINK_MS - 1);
            blink_d     = ~blink_q;
         end else begin
            blink_cnt_d = blink_cnt_q - 1'b1;
         end
      end
   end

   // FSM next-state, key execution and hold timers
   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      digits_d  = digits_q;
      cur_d     = cur_q;
      key_d     = key_q;
      key_vld_d = 1'b0;
      err_d     = err_q;
`ifdef IR_REPEAT_EN
      press_d   = press_q;
      gap_d     = gap_q;
      rep_d     = rep_q;
      if (tick && press_q != '0) press_d = press_q - 1'b1;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.i_frame_vld) begin
               frame_d = bus.i_frame;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (frame_ok) begin
               state_d = ST_EXEC;
            end else begin
               if (err_q != 8'hFF) err_d = err_q + 8'd1;
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            key_d     = f_cmd;
            key_vld_d = 1'b1;
            if (kd[4]) begin
               digits_d[{cur_q, 2'b00} +: 4] = kd[3:0];
               cur_d = cur_right;
            end else begin
               case (f_cmd)
                  KEY_LEFT:  cur_d = cur_left;
                  KEY_RIGHT: cur_d = cur_right;
                  KEY_UP:    digits_d[{cur_q, 2'b00} +: 4] =
                                (cur_dig >= 4'd9) ? 4'd0 : cur_dig + 4'd1;
                  KEY_DOWN:  digits_d[{cur_q, 2'b00} +: 4] =
                                (cur_dig == 4'd0) ? 4'd9 : cur_dig - 4'd1;
                  KEY_CLEAR: begin
                     digits_d = '0;
                     cur_d    = 3'd5;
                  end
                  default: ;
               endcase
            end
            state_d = ST_IDLE;
`ifdef IR_REPEAT_EN
            if (key_repeatable(f_cmd)) begin
               state_d = ST_HOLD;
               gap_d   = 16'(HOLD_TIMEOUT_MS);
               // press timer runs from the original press, not from repeats
               if (!rep_q) press_d = 16'(REPEAT_DELAY_MS);
            end
            rep_d = 1'b0;
`endif
         end
`ifdef IR_REPEAT_EN
         ST_HOLD: begin
            if (bus.i_frame_vld) begin
               frame_d = bus.i_frame;
               state_d = ST_CHECK;
            end else if (bus.i_repeat_vld) begin
               gap_d = 16'(HOLD_TIMEOUT_MS);
               if (press_q == '0) begin
                  state_d = ST_EXEC;
                  rep_d   = 1'b1;
               end
            end else if (gap_q == '0) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               gap_d = gap_q - 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         frame_q     <= '0;
         digits_q    <= '0;
         cur_q       <= 3'd5;
         key_q       <= '0;
         key_vld_q   <= 1'b0;
         err_q       <= '0;
         blink_cnt_q <= BW'(BLINK_MS - 1);
         blink_q     <= 1'b0;
`ifdef IR_REPEAT_EN
         press_q     <= '0;
         gap_q       <= '0;
         rep_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         digits_q    <= digits_d;
         cur_q       <= cur_d;
         key_q       <= key_d;
         key_vld_q   <= key_vld_d;
         err_q       <= err_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
`ifdef IR_REPEAT_EN
         press_q     <= press_d;
         gap_q       <= gap_d;
         rep_q       <= rep_d;
`endif
      end
   end

   assign bus.o_digits  = digits_q;
   assign bus.o_cursor  = 6'b000001 << cur_q;
   assign bus.o_dp      = blink_q ? (6'b000001 << cur_q) : 6'b000000;
   assign bus.o_key     = key_q;
   assign bus.o_key_vld = key_vld_q;
   assign bus.o_err_cnt = err_q;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Testbench for ir_key_ctrl: random key frames against a digit/cursor model,
// reject counting, wrap cases, blink, auto-repeat and mid-frame reset.
module tb_ir_key_ctrl;

   localparam int CLK_HZ   = 20_000;
   localparam int CPM      = CLK_HZ / 1000;
   localparam int RPT_DLY  = 500;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ir_key_ctrl_if bus ();

   ir_key_ctrl #(.CLK_HZ(CLK_HZ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int kv_cnt  = 0;

   logic [7:0] key_codes [10] = '{8'h16, 8'h0C, 8'h18, 8'h5E, 8'h08,
                                  8'h1C, 8'h5A, 8'h42, 8'h52, 8'h4A};
   logic [7:0] nav_codes [5]  = '{8'h44, 8'h40, 8'h15, 8'h07, 8'h45};

   int         m_dig [6];
   int         m_pos;
   logic [7:0] m_key;
   int         m_err;
   int         m_kv = 0;

   always @(negedge clk) if (bus.o_key_vld === 1'b1) kv_cnt++;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void m_reset();
      for (int i = 0; i < 6; i++) m_dig[i] = 0;
      m_pos = 5;
      m_key = 8'h00;
      m_err = 0;
   endfunction

   function automatic void m_apply(input logic [7:0] cmd);
      int d = -1;
      for (int i = 0; i < 10; i++) if (cmd == key_codes[i]) d = i;
      if (d >= 0) begin
         m_dig[m_pos] = d;
         m_pos = (m_pos + 5) % 6;
      end else begin
         case (cmd)
            8'h44: m_pos = (m_pos + 1) % 6;
            8'h40: m_pos = (m_pos + 5) % 6;
            8'h15: m_dig[m_pos] = (m_dig[m_pos] + 1) % 10;
            8'h07: m_dig[m_pos] = (m_dig[m_pos] + 9) % 10;
            8'h45: begin
               for (int i = 0; i < 6; i++) m_dig[i] = 0;
               m_pos = 5;
            end
            default: ;
         endcase
      end
      m_key = cmd;
      m_kv++;
   endfunction

   function automatic void m_reject();
      if (m_err < 255) m_err++;
   endfunction

   function automatic logic [23:0] m_digits();
      logic [23:0] r;
      for (int i = 0; i < 6; i++) r[i*4 +: 4] = 4'(m_dig[i]);
      return r;
   endfunction

   function automatic logic [5:0] m_cursor();
      return 6'(1 << m_pos);
   endfunction

   function automatic logic [31:0] good_frame(input logic [7:0] cmd);
      return {8'h00, 8'hFF, cmd, ~cmd};
   endfunction

   function automatic logic [31:0] bad_frame(input logic [7:0] cmd);
      logic [7:0] c = 8'($urandom_range(1, 255));
      case ($urandom_range(0, 2))
         0:       return {c, ~c, cmd, ~cmd};
         1:       return {8'h00, 8'hFF ^ c, cmd, ~cmd};
         default: return {8'h00, 8'hFF, cmd, ~cmd ^ c};
      endcase
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_reset();
   endtask

   // returns 1 time unit after E2
   task automatic send_frame(input logic [31:0] f);
      @(posedge clk); #1;
      bus.i_frame_vld = 1'b1;
      bus.i_frame     = f;
      @(posedge clk); #1;
      bus.i_frame_vld = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
   endtask

   // returns 1 time unit after R1
   task automatic pulse_repeat();
      @(posedge clk); #1;
      bus.i_repeat_vld = 1'b1;
      @(posedge clk); #1;
      bus.i_repeat_vld = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();
      n_tests++; if (bus.o_digits !== 24'h0) begin n_fail++; $display("FAIL reset_digits got %h exp %h", bus.o_digits, 24'h0); end
      n_tests++; if (bus.o_cursor !== 6'b100000) begin n_fail++; $display("FAIL reset_cursor got %b exp %b", bus.o_cursor, 6'b100000); end
      n_tests++; if (bus.o_dp !== 6'b0) begin n_fail++; $display("FAIL reset_dp got %b exp 0", bus.o_dp); end
      n_tests++; if (bus.o_key !== 8'h0) begin n_fail++; $display("FAIL reset_key got %h exp 00", bus.o_key); end
      n_tests++; if (bus.o_key_vld !== 1'b0) begin n_fail++; $display("FAIL reset_key_vld got %b exp 0", bus.o_key_vld); end
      n_tests++; if (bus.o_err_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_err got %h exp 00", bus.o_err_cnt); end
   endtask

   task automatic test_key1();
      int kv0 = kv_cnt;
      @(posedge clk); #1;
      bus.i_frame_vld = 1'b1;
      bus.i_frame     = 32'h00FF0CF3;
      @(posedge clk); #1;
      bus.i_frame_vld = 1'b0;
      @(posedge clk); #1;
      n_tests++; if (bus.o_digits !== 24'h0) begin n_fail++; $display("FAIL key1_e1_digits got %h exp %h", bus.o_digits, 24'h0); end
      @(posedge clk); #1;
      m_apply(8'h0C);
      n_tests++; if (bus.o_digits !== 24'h100000) begin n_fail++; $display("FAIL key1_digits got %h exp %h", bus.o_digits, 24'h100000); end
      n_tests++; if (bus.o_cursor !== 6'b010000) begin n_fail++; $display("FAIL key1_cursor got %b exp %b", bus.o_cursor, 6'b010000); end
      n_tests++; if (bus.o_key !== 8'h0C) begin n_fail++; $display("FAIL key1_key got %h exp 0c", bus.o_key); end
      n_tests++; if (bus.o_key_vld !== 1'b1) begin n_fail++; $display("FAIL key1_vld_hi got %b exp 1", bus.o_key_vld); end
      @(posedge clk); #1;
      n_tests++; if (bus.o_key_vld !== 1'b0) begin n_fail++; $display("FAIL key1_vld_lo got %b exp 0", bus.o_key_vld); end
      n_tests++; if (kv_cnt !== kv0 + 1) begin n_fail++; $display("FAIL key1_vld_count got %0d exp %0d", kv_cnt, kv0 + 1); end
   endtask

   task automatic test_bad_frames();
      @(posedge clk); #1;
      bus.i_frame_vld = 1'b1;
      bus.i_frame     = 32'h00FF0C00;
      @(posedge clk); #1;
      bus.i_frame_vld = 1'b0;
      @(posedge clk); #1;
      m_reject();
      n_tests++; if (bus.o_err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL bad_err_e1 got %0d exp %0d", bus.o_err_cnt, m_err); end
      @(posedge clk); #1;
      n_tests++; if (bus.o_digits !== m_digits()) begin n_fail++; $display("FAIL bad_no_edit got %h exp %h", bus.o_digits, m_digits()); end
      for (int i = 0; i < 300; i++) begin
         send_frame(bad_frame(8'($urandom_range(0, 255))));
         m_reject();
      end
      n_tests++; if (bus.o_err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_saturate got %0d exp 255", bus.o_err_cnt); end
      n_tests++; if (bus.o_digits !== m_digits()) begin n_fail++; $display("FAIL bad_digits got %h exp %h", bus.o_digits, m_digits()); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         send_frame(good_frame(8'h40));
         m_apply(8'h40);
         n_tests++; if (bus.o_cursor !== m_cursor()) begin n_fail++; $display("FAIL right_step%0d got %b exp %b", i, bus.o_cursor, m_cursor()); end
      end
      n_tests++; if (bus.o_cursor !== 6'b100000) begin n_fail++; $display("FAIL right_wrap got %b exp %b", bus.o_cursor, 6'b100000); end
      send_frame(good_frame(8'h07));
      m_apply(8'h07);
      n_tests++; if (bus.o_digits[23:20] !== 4'd9) begin n_fail++; $display("FAIL down_wrap got %0d exp 9", bus.o_digits[23:20]); end
      send_frame(good_frame(8'h15));
      m_apply(8'h15);
      n_tests++; if (bus.o_digits[23:20] !== 4'd0) begin n_fail++; $display("FAIL up_wrap got %0d exp 0", bus.o_digits[23:20]); end
      send_frame(good_frame(8'h44));
      m_apply(8'h44);
      n_tests++; if (bus.o_cursor !== 6'b000001) begin n_fail++; $display("FAIL left_wrap got %b exp %b", bus.o_cursor, 6'b000001); end
   endtask

   task automatic test_random_keys();
      logic [7:0]  cmd;
      logic [31:0] f;
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: cmd = key_codes[$urandom_range(0, 9)];
            4, 5, 6:    cmd = nav_codes[$urandom_range(0, 4)];
            default:    cmd = 8'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 4) == 0) begin
            f = bad_frame(cmd);
            m_reject();
         end else begin
            f = good_frame(cmd);
            m_apply(cmd);
         end
         send_frame(f);
         n_tests++; if (bus.o_digits !== m_digits()) begin n_fail++; $display("FAIL rand%0d_digits got %h exp %h", i, bus.o_digits, m_digits()); end
         n_tests++; if (bus.o_cursor !== m_cursor()) begin n_fail++; $display("FAIL rand%0d_cursor got %b exp %b", i, bus.o_cursor, m_cursor()); end
         n_tests++; if (bus.o_key !== m_key) begin n_fail++; $display("FAIL rand%0d_key got %h exp %h", i, bus.o_key, m_key); end
         n_tests++; if (bus.o_err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL rand%0d_err got %0d exp %0d", i, bus.o_err_cnt, m_err); end
         @(posedge clk); #1;
         n_tests++; if (kv_cnt !== m_kv) begin n_fail++; $display("FAIL rand%0d_kv_count got %0d exp %0d", i, kv_cnt, m_kv); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a = key_codes[$urandom_range(0, 9)];
      logic [7:0] b = key_codes[$urandom_range(0, 9)];
      @(posedge clk); #1;
      bus.i_frame_vld  = 1'b1;
      bus.i_frame      = good_frame(a);
      bus.i_repeat_vld = 1'b1;
      @(posedge clk); #1;
      bus.i_repeat_vld = 1'b0;
      bus.i_frame      = good_frame(b);
      @(posedge clk); #1;
      bus.i_frame_vld  = 1'b0;
      m_apply(a);
      repeat (4) @(posedge clk);
      #1;
      n_tests++; if (bus.o_digits !== m_digits()) begin n_fail++; $display("FAIL b2b_digits got %h exp %h", bus.o_digits, m_digits()); end
      n_tests++; if (bus.o_cursor !== m_cursor()) begin n_fail++; $display("FAIL b2b_cursor got %b exp %b", bus.o_cursor, m_cursor()); end
      n_tests++; if (kv_cnt !== m_kv) begin n_fail++; $display("FAIL b2b_kv_count got %0d exp %0d", kv_cnt, m_kv); end
      n_tests++; if (bus.o_err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL b2b_err got %0d exp %0d", bus.o_err_cnt, m_err); end
   endtask

   task automatic test_blink();
      do_reset();
      repeat (240 * CPM) @(posedge clk);
      #1;
      n_tests++; if (bus.o_dp !== 6'b0) begin n_fail++; $display("FAIL blink_240ms got %b exp 0", bus.o_dp); end
      repeat (20 * CPM) @(posedge clk);
      #1;
      n_tests++; if (bus.o_dp !== 6'b100000) begin n_fail++; $display("FAIL blink_260ms got %b exp %b", bus.o_dp, 6'b100000); end
      repeat (250 * CPM) @(posedge clk);
      #1;
      n_tests++; if (bus.o_dp !== 6'b0) begin n_fail++; $display("FAIL blink_510ms got %b exp 0", bus.o_dp); end
   endtask

   task automatic test_repeat();
      logic [3:0] exp_final;
      do_reset();
      send_frame(good_frame(8'h15));
      m_apply(8'h15);
      n_tests++; if (bus.o_digits[23:20] !== 4'd1) begin n_fail++; $display("FAIL rpt_press got %0d exp 1", bus.o_digits[23:20]); end
      for (int k = 1; k <= 9; k++) begin
         repeat (108 * CPM - 3) @(posedge clk);
         pulse_repeat();
`ifdef IR_REPEAT_EN
         if (k * 108 >= RPT_DLY) m_apply(8'h15);
`endif
         @(posedge clk); #1;
         n_tests++; if (bus.o_digits !== m_digits()) begin n_fail++; $display("FAIL rpt%0d_digits got %h exp %h", k, bus.o_digits, m_digits()); end
         n_tests++; if (kv_cnt !== m_kv) begin n_fail++; $display("FAIL rpt%0d_kv_count got %0d exp %0d", k, kv_cnt, m_kv); end
      end
`ifdef IR_REPEAT_EN
      exp_final = 4'd6;
`else
      exp_final = 4'd1;
`endif
      n_tests++; if (bus.o_digits[23:20] !== exp_final) begin n_fail++; $display("FAIL rpt_final got %0d exp %0d", bus.o_digits[23:20], exp_final); end
      repeat (130 * CPM) @(posedge clk);
      pulse_repeat();
      @(posedge clk); #1;
      n_tests++; if (bus.o_digits !== m_digits()) begin n_fail++; $display("FAIL rpt_after_timeout got %h exp %h", bus.o_digits, m_digits()); end
      n_tests++; if (kv_cnt !== m_kv) begin n_fail++; $display("FAIL rpt_timeout_kv got %0d exp %0d", kv_cnt, m_kv); end
   endtask

   task automatic test_rst_mid_frame();
      int kv0;
      send_frame(good_frame(8'h42));
      m_apply(8'h42);
      send_frame(bad_frame(8'h42));
      m_reject();
      repeat (2) @(posedge clk);
      #1;
      kv0 = kv_cnt;
      @(posedge clk); #1;
      bus.i_frame_vld = 1'b1;
      bus.i_frame     = good_frame(8'h0C);
      @(posedge clk); #1;
      bus.i_frame_vld = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_reset();
      n_tests++; if (bus.o_digits !== 24'h0) begin n_fail++; $display("FAIL rstmid_digits got %h exp 0", bus.o_digits); end
      n_tests++; if (bus.o_cursor !== 6'b100000) begin n_fail++; $display("FAIL rstmid_cursor got %b exp %b", bus.o_cursor, 6'b100000); end
      n_tests++; if (bus.o_dp !== 6'b0) begin n_fail++; $display("FAIL rstmid_dp got %b exp 0", bus.o_dp); end
      n_tests++; if (bus.o_key !== 8'h0) begin n_fail++; $display("FAIL rstmid_key got %h exp 00", bus.o_key); end
      n_tests++; if (bus.o_err_cnt !== 8'h0) begin n_fail++; $display("FAIL rstmid_err got %0d exp 0", bus.o_err_cnt); end
      repeat (5) @(posedge clk);
      #1;
      n_tests++; if (bus.o_digits !== 24'h0) begin n_fail++; $display("FAIL rstmid_late_digits got %h exp 0", bus.o_digits); end
      n_tests++; if (bus.o_key_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_key_vld got %b exp 0", bus.o_key_vld); end
      n_tests++; if (kv_cnt !== kv0) begin n_fail++; $display("FAIL rstmid_kv_count got %0d exp %0d", kv_cnt, kv0); end
   endtask

   initial begin
      bus.i_frame_vld  = 1'b0;
      bus.i_frame      = 32'h0;
      bus.i_repeat_vld = 1'b0;
      test_reset();
      test_key1();
      test_bad_frames();
      test_wrap();
      test_random_keys();
      test_back_to_back();
      test_rst_mid_frame();
      test_blink();
      test_repeat();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ir_key_ctrl.md
# ir_key_ctrl

Command controller between the NEC IR receiver and the six-digit segment display. It takes decoded 32-bit frames and validates the custom code and the inverted bytes. Each valid key is turned into an edit of a six-digit BCD value with a movable, blinking cursor. The BCD outputs feed the per-digit segment decoders, and the cursor drives the decimal points. Held keys are auto-repeated from NEC repeat codes.

## Interface
- CLK_HZ, 50_000_000: clk frequency; sets the 1 ms tick divider.
- CUSTOM_CODE, 8'h00: accepted NEC custom (address) byte.
- REPEAT_DELAY_MS, 500: time from the original press before repeat codes take effect.
- HOLD_TIMEOUT_MS, 120: maximum gap between repeat codes before the hold ends.
- BLINK_MS, 250: cursor blink half-period.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous and active-high.
- i_frame_vld  in  1  one-cycle pulse: i_frame holds a new frame.
- i_frame  in  32  [31:24] custom, [23:16] ~custom, [15:8] cmd, [7:0] ~cmd.
- i_repeat_vld  in  1  one-cycle pulse: an NEC repeat code was received.
- o_digits  out  24  six BCD digits; [3:0] is the rightmost digit (digit0).
- o_cursor  out  6  one-hot cursor position; bit5 is the leftmost digit.
- o_dp  out  6  o_cursor while the blink phase is 1, otherwise 0.
- o_key  out  8  command byte of the last executed key.
- o_key_vld  out  1  one-cycle pulse per executed key, including repeats.
- o_err_cnt  out  8  count of rejected frames; saturates at 255.

## Operation
- Reset values: o_digits 0, o_cursor 6'b100000, o_dp 0, o_key 0, o_key_vld 0, o_err_cnt 0, blink phase 0, state IDLE.
- States: IDLE, CHECK, EXEC, HOLD.
- IDLE/HOLD: i_frame_vld latches i_frame and moves to CHECK.
- CHECK, all three must hold, otherwise the frame is rejected:
  - custom == CUSTOM_CODE
  - byte[23:16] == ~custom
  - byte[7:0] == ~cmd
- CHECK on reject: o_err_cnt increments (saturating) and the state returns to IDLE.
- CHECK on accept: go to EXEC.
- EXEC: apply the key, set o_key = cmd, pulse o_key_vld. Next state:
  - HOLD if the key is repeatable and IR_REPEAT_EN is set;
  - IDLE otherwise.
- Key actions. Position arithmetic is mod 6, digit arithmetic is mod 10.
  - Digit keys 0-9: write the value at the cursor, then move the cursor right; digit0 wraps to digit5.
  - LEFT: cursor moves left; digit5 wraps to digit0.
  - RIGHT: cursor moves right; digit0 wraps to digit5.
  - UP: cursor digit +1; 9 wraps to 0.
  - DOWN: cursor digit -1; 0 wraps to 9.
  - CLEAR: all digits 0, cursor to digit5.
  - Any other valid cmd: o_key/o_key_vld update, no edit.
- Only UP, DOWN, LEFT and RIGHT are repeatable.
- HOLD has two timers, both driven by the 1 ms tick:
  - press timer: counts from EXEC of the original press;
  - gap timer: cleared by each i_repeat_vld.
- HOLD on i_repeat_vld:
  - press timer ≥ REPEAT_DELAY_MS: re-enter EXEC with the latched cmd;
  - otherwise: only the gap timer clears.
- HOLD: gap timer reaching HOLD_TIMEOUT_MS returns to IDLE.
- Blink phase toggles every BLINK_MS, free-running.

## Timing
- i_frame_vld is sampled at edge E0.
- Rejected frame: o_err_cnt updates at E1.
- Accepted frame: o_digits, o_cursor, o_key update at E2; o_key_vld is high for the cycle after E2.
- Repeat sampled at edge R0: outputs update at R1.
- i_frame_vld while in CHECK or EXEC: dropped, no count.
- i_frame_vld and i_repeat_vld in the same cycle: the frame wins and the repeat is ignored.
- i_repeat_vld in IDLE, CHECK or EXEC: ignored.
- rst high at any edge: all state and outputs take reset values at that edge; a latched frame is discarded and the ms/blink counters clear.

## Configuration
- IR_REPEAT_EN defined: HOLD state, press/gap timers and auto-repeat are built as described.
- IR_REPEAT_EN undefined:
  - no HOLD state; EXEC always returns to IDLE;
  - i_repeat_vld is kept on the port but ignored;
  - REPEAT_DELAY_MS and HOLD_TIMEOUT_MS are unused.

## Structure
- Package ir_ctrl_pkg holds:
  - state encoding;
  - NEC field bit positions;
  - key codes: 0-9 = 16,0C,18,5E,08,1C,5A,42,52,4A (hex); LEFT 44, RIGHT 40, UP 15, DOWN 07, CLEAR 45.
- Sub-module ms_tick: CLK_HZ/1000 divider producing a one-cycle 1 ms pulse, synchronous active-high reset. It is shared by the blink, press and gap timers.

## Test plan
- Frame 32'h00FF0CF3 (key 1) after reset: o_digits=24'h100000 and o_cursor=6'b010000 at E2; one o_key_vld with o_key=8'h0C.
- Frame with a bad cmd complement (32'h00FF0C00): no edit, o_err_cnt=1. Also apply 300 bad frames and check o_err_cnt=255.
- Wrap checks:
  - RIGHT ×6 from reset: cursor returns to 6'b100000;
  - DOWN at digit value 0: digit becomes 9;
  - UP at 9: digit becomes 0.
- IR_REPEAT_EN defined: UP frame, then i_repeat_vld every 108 ms for 1 s. Digit must be 1 after the press; repeats after 500 ms each add 1. Silence for 120 ms must give IDLE.
- IR_REPEAT_EN undefined: same stimulus; digit ends at 1 and no further o_key_vld pulses occur.
- rst asserted one cycle after i_frame_vld: no digit change, no o_key_vld, all outputs at reset values.
